// File: rtl/sbox_lane_scheduler.sv
// sbox_lane_scheduler
// Shares one 32-bit forward S-box lane between the cipher round datapath
// (128-bit SubBytes, four column beats) and the key expansion (32-bit
// SubWord, one beat). Arbitration alternates on contention via a
// last-grant bit; results are held until the next completion of the
// same requester.
module sbox_lane_scheduler #(
    parameter bit KEY_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_valid,
    input  logic [127:0] st_data,
    output logic         st_ready,
    output logic         st_done,
    output logic [127:0] st_result,
    input  logic         kw_valid,
    input  logic [31:0]  kw_data,
    output logic         kw_ready,
    output logic         kw_done,
    output logic [31:0]  kw_result,
    output logic [31:0]  lane_in,
    input  logic [31:0]  lane_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_KEY  = 2'd1,
        S_ST   = 2'd2
    } state_t;

    // lg_key = 1 means the key requester won the most recent grant.
    // With KEY_FIRST the reset value claims "state" went last so key wins first.
    localparam bit LG_KEY_RST = !KEY_FIRST;

    state_t        state;
    logic [1:0]    beat;
    logic          lg_key;
    logic [127:0]  st_buf;
    logic [31:0]   kw_buf;
    logic [95:0]   shadow;
    logic          st_acc;
    logic          kw_acc;
    logic          is_idle;

    assign is_idle  = (state == S_IDLE);
    // On contention the requester that did not win last time gets the lane.
    assign kw_ready = is_idle && kw_valid && (!st_valid || !lg_key);
    assign st_ready = is_idle && st_valid && (!kw_valid ||  lg_key);
    assign kw_acc   = kw_valid && kw_ready;
    assign st_acc   = st_valid && st_ready;

    // Lane input: captured word during KEY, the column selected by beat during ST.
    always_comb begin
        lane_in = 32'd0;
        case (state)
            S_KEY: lane_in = kw_buf;
            S_ST: begin
                case (beat)
                    2'd0:    lane_in = st_buf[127:96];
                    2'd1:    lane_in = st_buf[95:64];
                    2'd2:    lane_in = st_buf[63:32];
                    default: lane_in = st_buf[31:0];
                endcase
            end
            default: lane_in = 32'd0;
        endcase
    end

    // Control, sequencing and result registers; reset discards any job in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            beat      <= 2'd0;
            lg_key    <= LG_KEY_RST;
            st_done   <= 1'b0;
            kw_done   <= 1'b0;
            st_result <= 128'd0;
            kw_result <= 32'd0;
        end else begin
            st_done <= 1'b0;
            kw_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    beat <= 2'd0;
                    if (kw_acc) begin
                        state  <= S_KEY;
                        lg_key <= 1'b1;
                    end else if (st_acc) begin
                        state  <= S_ST;
                        lg_key <= 1'b0;
                    end
                end
                S_KEY: begin
                    kw_result <= lane_out;
                    kw_done   <= 1'b1;
                    state     <= S_IDLE;
                end
                S_ST: begin
                    beat <= beat + 2'd1;
                    if (beat == 2'd3) begin
                        // Publish the whole state at once so no partial value is visible.
                        st_result <= {shadow, lane_out};
                        st_done   <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    beat  <= 2'd0;
                end
            endcase
        end
    end

    // Job buffers and the column shadow; pure data, no reset needed.
    always_ff @(posedge clk) begin
        if (kw_acc) begin
            kw_buf <= kw_data;
        end
        if (st_acc) begin
            st_buf <= st_data;
        end
        if (state == S_ST) begin
            case (beat)
                2'd0:    shadow[95:64] <= lane_out;
                2'd1:    shadow[63:32] <= lane_out;
                2'd2:    shadow[31:0]  <= lane_out;
                default: shadow        <= shadow;
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_lane_scheduler.sv
// Testbench for sbox_lane_scheduler: an AES forward S-box model drives
// lane_out, directed vectors with hand-computed results are applied from a
// table, and multi-cycle corner cases are written out as sequences.
module tb_sbox_lane_scheduler;

    localparam logic [2047:0] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         st_valid = 1'b0;
    logic [127:0] st_data = 128'd0;
    logic         st_ready;
    logic         st_done;
    logic [127:0] st_result;
    logic         kw_valid = 1'b0;
    logic [31:0]  kw_data = 32'd0;
    logic         kw_ready;
    logic         kw_done;
    logic [31:0]  kw_result;
    logic [31:0]  lane_in;
    logic [31:0]  lane_out;

    int total = 0;
    int bad = 0;
    logic [127:0] st_prev = 128'd0;

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [2047:0] t;
        t = SBOX_TAB;
        return t[(255 - int'(x)) * 8 +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
    endfunction

    assign lane_out = sub_word(lane_in);

    always #5 clk = ~clk;

    sbox_lane_scheduler #(.KEY_FIRST(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .st_valid  (st_valid),
        .st_data   (st_data),
        .st_ready  (st_ready),
        .st_done   (st_done),
        .st_result (st_result),
        .kw_valid  (kw_valid),
        .kw_data   (kw_data),
        .kw_ready  (kw_ready),
        .kw_done   (kw_done),
        .kw_result (kw_result),
        .lane_in   (lane_in),
        .lane_out  (lane_out)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        st_prev = 128'd0;
    endtask

    task automatic run_key(input logic [31:0] data, input logic [31:0] exp);
        int lat;
        bit st_seen;
        @(negedge clk);
        kw_valid = 1'b1;
        kw_data  = data;
        #1 chk("kw_ready_accept", kw_ready, 1'b1);
        @(negedge clk);
        kw_valid = 1'b0;
        kw_data  = ~data;
        #1 chk("kw_lane_in", lane_in, data);
        lat = 1;
        st_seen = st_done;
        while (!kw_done && lat < 8) begin
            @(negedge clk);
            #1;
            lat++;
            st_seen = st_seen | st_done;
        end
        chk("kw_latency", lat, 2);
        chk("kw_result", kw_result, exp);
        chk("kw_no_st_done", st_seen, 1'b0);
    endtask

    task automatic run_state(input logic [127:0] data, input logic [127:0] exp);
        int lat;
        @(negedge clk);
        st_valid = 1'b1;
        st_data  = data;
        #1 chk("st_ready_accept", st_ready, 1'b1);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            if (b == 0) begin
                st_valid = 1'b0;
                st_data  = ~data;
            end
            #1;
            chk("st_lane_in_beat", lane_in, data[127 - 32 * b -: 32]);
            chk("st_result_hold", st_result, st_prev);
            chk("st_done_early", st_done, 1'b0);
        end
        lat = 4;
        while (!st_done && lat < 10) begin
            @(negedge clk);
            #1;
            lat++;
        end
        chk("st_latency", lat, 5);
        chk("st_result", st_result, exp);
        st_prev = exp;
    endtask

    typedef struct {
        bit           is_key;
        logic [127:0] data;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [10:0] kr_v, sr_v, kd_v, sd_v;
        bit both_rdy, st_seen;

        vecs[0] = '{1'b1, 128'hcf4f3c09, 128'h8a84eb01};
        vecs[1] = '{1'b0, 128'h000102030405060708090a0b0c0d0e0f,
                          128'h637c777bf26b6fc53001672bfed7ab76};
        vecs[2] = '{1'b1, 128'h00000000, 128'h63636363};
        vecs[3] = '{1'b1, 128'hffffffff, 128'h16161616};
        vecs[4] = '{1'b1, 128'h01020304, 128'h7c777bf2};
        vecs[5] = '{1'b0, 128'h00112233445566778899aabbccddeeff,
                          128'h638293c31bfc33f5c4eeacea4bc12816};
        vecs[6] = '{1'b0, {128{1'b1}}, {16{8'h16}}};

        // asynchronous reset before any clock edge
        #3 rst = 1'b1;
        #1;
        chk("rst_st_done", st_done, 1'b0);
        chk("rst_kw_done", kw_done, 1'b0);
        chk("rst_st_result", st_result, 128'd0);
        chk("rst_kw_result", kw_result, 32'd0);
        chk("rst_lane_in", lane_in, 32'd0);
        chk("rst_readies", {st_ready, kw_ready}, 2'b00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // readies follow valids in IDLE; valids dropped before the edge
        @(negedge clk);
        st_valid = 1'b1;
        #1 chk("idle_st_only", {st_ready, kw_ready}, 2'b10);
        st_valid = 1'b0;
        kw_valid = 1'b1;
        #1 chk("idle_kw_only", {st_ready, kw_ready}, 2'b01);
        kw_valid = 1'b0;
        #1 chk("idle_none", {st_ready, kw_ready}, 2'b00);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].is_key) run_key(vecs[i].data[31:0], vecs[i].exp[31:0]);
            else                run_state(vecs[i].data, vecs[i].exp);
        end

        // contention from reset: key, state, key, state
        reset_dut();
        kw_valid = 1'b1;
        kw_data  = 32'hcf4f3c09;
        st_valid = 1'b1;
        st_data  = 128'h000102030405060708090a0b0c0d0e0f;
        both_rdy = 1'b0;
        for (int c = 0; c < 11; c++) begin
            #1;
            kr_v[c] = kw_ready;
            sr_v[c] = st_ready;
            kd_v[c] = kw_done;
            sd_v[c] = st_done;
            both_rdy = both_rdy | (kw_ready & st_ready);
            @(negedge clk);
        end
        kw_valid = 1'b0;
        st_valid = 1'b0;
        chk("cont_kw_ready", kr_v, 11'h081);
        chk("cont_st_ready", sr_v, 11'h204);
        chk("cont_kw_done", kd_v, 11'h204);
        chk("cont_st_done", sd_v, 11'h080);
        chk("cont_both_ready", both_rdy, 1'b0);
        chk("cont_kw_result", kw_result, 32'h8a84eb01);
        chk("cont_st_result", st_result, 128'h637c777bf26b6fc53001672bfed7ab76);

        // back-to-back state jobs
        reset_dut();
        st_valid = 1'b1;
        st_data  = 128'd0;
        #1 chk("b2b_accept1", st_ready, 1'b1);
        @(negedge clk);
        st_data = 128'h000102030405060708090a0b0c0d0e0f;
        for (int k = 2; k <= 5; k++) @(negedge clk);
        #1;
        chk("b2b_done1", st_done, 1'b1);
        chk("b2b_accept2", st_ready, 1'b1);
        chk("b2b_result1", st_result, {16{8'h63}});
        @(negedge clk);
        st_valid = 1'b0;
        for (int k = 6; k <= 9; k++) begin
            #1;
            chk("b2b_hold", st_result, {16{8'h63}});
            chk("b2b_no_done", st_done, 1'b0);
            @(negedge clk);
        end
        #1;
        chk("b2b_done2", st_done, 1'b1);
        chk("b2b_result2", st_result, 128'h637c777bf26b6fc53001672bfed7ab76);

        // reset during beat 2 of a state job
        @(negedge clk);
        st_valid = 1'b1;
        st_data  = {128{1'b1}};
        #1 chk("mid_accept", st_ready, 1'b1);
        @(negedge clk);
        st_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 chk("mid_beat2_lane", lane_in, 32'hffffffff);
        rst = 1'b1;
        #1;
        chk("mid_rst_result", st_result, 128'd0);
        chk("mid_rst_lane", lane_in, 32'd0);
        chk("mid_rst_done", st_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        st_prev = 128'd0;
        st_seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1 st_seen = st_seen | st_done;
            @(negedge clk);
        end
        chk("mid_no_done", st_seen, 1'b0);
        chk("mid_result_zero", st_result, 128'd0);
        run_state(128'h000102030405060708090a0b0c0d0e0f,
                  128'h637c777bf26b6fc53001672bfed7ab76);
        run_key(32'hcf4f3c09, 32'h8a84eb01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
